// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock into a
// single signed accumulator, with valid/ready handshakes on operands and product.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on valid, and once raised
  // out_valid and product stay stable until the transfer completes.

  localparam int EXT_W   = WIDTH + 2;
  localparam int ACC_W   = 2 * WIDTH + 4;
  localparam int NUM_DIG = WIDTH / 2 + 1;
  localparam int CNT_W   = $clog2(NUM_DIG + 1);

  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [EXT_W-1:0] m_ext;
  // Extended multiplier with the implicit x[-1]=0 held in bit 0.
  logic [EXT_W:0]   x_ext;
  logic [CNT_W-1:0] digit;
  logic [ACC_W-1:0] acc;

  logic [CNT_W:0]   shift_amt;
  logic [2:0]       triplet;
  logic [ACC_W-1:0] m_wide;
  logic [ACC_W-1:0] pp;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    shift_amt = {digit, 1'b0};
    triplet   = 3'(x_ext >> shift_amt);
    m_wide    = {{(ACC_W - EXT_W){m_ext[EXT_W-1]}}, m_ext};
    pp        = '0;
    case (triplet)
      3'b001, 3'b010: pp = m_wide;
      3'b011:         pp = m_wide << 1;
      3'b100:         pp = -(m_wide << 1);
      3'b101, 3'b110: pp = -m_wide;
      default:        pp = '0;
    endcase
    acc_next = acc + (pp << shift_amt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_ext   <= '0;
      x_ext   <= '0;
      digit   <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // signed_mode is folded into the extension, so it need not be kept.
            m_ext <= {{2{signed_mode & a[WIDTH-1]}}, a};
            x_ext <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
            acc   <= '0;
            digit <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          digit <= digit + CNT_W'(1);
          if (digit == LAST_DIG) begin
            product <= acc_next[2*WIDTH-1:0];
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=8 and WIDTH=16 instances behind one driver,
// checked every cycle against an arithmetic reference with an expected queue.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        sm;
  logic        out_ready;
  logic        sel;
  logic [15:0] a;
  logic [15:0] b;
  logic        pin_has;
  logic [31:0] pin_lit;

  logic        ir8, ov8, bz8;
  logic [15:0] p8;
  logic        ir16, ov16, bz16;
  logic [31:0] p16;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .signed_mode(sm), .out_valid(ov8),
    .out_ready(out_ready & ~sel), .product(p8), .busy(bz8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir16),
    .a(a), .b(b), .signed_mode(sm), .out_valid(ov16),
    .out_ready(out_ready & sel), .product(p16), .busy(bz16)
  );

  logic        in_ready_m, out_valid_m, busy_m;
  logic [31:0] product_m;
  assign in_ready_m  = sel ? ir16 : ir8;
  assign out_valid_m = sel ? ov16 : ov8;
  assign busy_m      = sel ? bz16 : bz8;
  assign product_m   = sel ? p16 : {16'h0, p8};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int to_cnt = 0;
  int to_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference product of the operands as the chosen mode interprets them.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input int w);
    longint mask;
    longint xv;
    longint yv;
    longint p;
    mask = (longint'(1) << w) - 1;
    xv = longint'(x) & mask;
    yv = longint'(y) & mask;
    if (s && (((xv >> (w - 1)) & 1) != 0)) xv = xv - (longint'(1) << w);
    if (s && (((yv >> (w - 1)) & 1) != 0)) yv = yv - (longint'(1) << w);
    p = xv * yv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] exp_q[$];
  logic [32:0] pin_q[$];
  logic        chk_en = 1'b0;
  logic        mbusy = 1'b0;
  int          acc_edge = 0;
  logic [31:0] last_prod [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d sel=%0d", name, got, want, cyc, sel);
    end
  endtask

  always @(negedge clk) begin
    logic        e_ov;
    logic [31:0] e_p;
    logic [31:0] v;
    logic [32:0] pv;
    int          w;
    int          nd;
    if (to_cnt != to_seen) begin
      total++;
      bad++;
      $display("FAIL driver_timeout got=%0d want=%0d", to_cnt, to_seen);
      to_seen = to_cnt;
    end
    if (rst) begin
      exp_q.delete();
      pin_q.delete();
      mbusy = 1'b0;
      last_prod[0] = '0;
      last_prod[1] = '0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      w  = sel ? 16 : 8;
      nd = w / 2 + 1;
      e_ov = mbusy && (cyc >= acc_edge + nd);
      e_p  = e_ov ? exp_q[0] : last_prod[sel];
      chk("out_valid", 32'(out_valid_m), 32'(e_ov));
      chk("in_ready", 32'(in_ready_m), 32'(!mbusy));
      chk("busy", 32'(busy_m), 32'(mbusy));
      chk("product", product_m, e_p);
      if (e_ov && out_ready) begin
        v  = exp_q.pop_front();
        pv = pin_q.pop_front();
        if (pv[32]) begin
          chk("pin_model", v, pv[31:0]);
          chk("pin_product", product_m, pv[31:0]);
        end
        last_prod[sel] = v;
        mbusy = 1'b0;
      end else if (!mbusy && in_valid) begin
        exp_q.push_back(ref_mul(a, b, sm, w));
        pin_q.push_back({pin_has, pin_lit});
        mbusy = 1'b1;
        acc_edge = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic s,
                      input logic has, input logic [31:0] lit);
    bit ok;
    ok = 1'b0;
    a = av; b = bv; sm = s; pin_has = has; pin_lit = lit;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready_m) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    pin_has  = 1'b0;
    if (!ok) begin
      to_cnt++;
      $display("FAIL send_timeout a=%0h b=%0h", av, bv);
    end
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_valid_m) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      to_cnt++;
      $display("FAIL wait_valid_timeout");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (in_ready_m && !out_valid_m) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      to_cnt++;
      $display("FAIL wait_idle_timeout");
    end
  endtask

  task automatic run(input logic [15:0] av, input logic [15:0] bv, input logic s,
                     input logic [31:0] lit);
    send(av, bv, s, 1'b1, lit);
    wait_idle(50);
  endtask

  task automatic random_phase(input logic which, input int n_txn);
    int accepts;
    int guard;
    accepts = 0;
    guard = 0;
    sel = which;
    while (accepts < n_txn && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      sm        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready_m) accepts++;
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (accepts < n_txn) begin
      to_cnt++;
      $display("FAIL random_budget accepts=%0d want=%0d", accepts, n_txn);
    end
    wait_idle(100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    a = '0; b = '0; sm = 1'b0; pin_has = 1'b0; pin_lit = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    run(16'd10,  16'd10,  1'b0, 32'd100);
    run(16'd255, 16'd255, 1'b0, 32'd65025);
    run(16'd200, 16'd210, 1'b0, 32'd42000);
    run(16'h80,  16'h80,  1'b1, 32'h4000);
    run(16'hFF,  16'hFF,  1'b1, 32'h0001);
    run(16'h7F,  16'h80,  1'b1, 32'hC080);
    run(16'h00,  16'h80,  1'b1, 32'h0000);

    // Output held under backpressure while new operands are offered.
    out_ready = 1'b0;
    send(16'd15, 16'd20, 1'b0, 1'b1, 32'd300);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      in_valid = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_idle(50);

    // Reset two cycles into the calculation.
    send(16'd7, 16'd9, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run(16'd30, 16'd40, 1'b0, 32'd1200);

    sel = 1'b1;
    run(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);

    random_phase(1'b0, 2000);
    random_phase(1'b1, 2000);

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised, iterative radix-4 Booth multiplier. Successor to the combinational 8-bit Booth partial-product generator and 16-bit CLA adder chain.
- Retires one Booth digit per clock into a single accumulator, so area does not grow with the number of partial products.
- Supports signed and unsigned operands, selected per transaction.
- Uses valid/ready handshakes on input and output; sits between operand-issue logic and result consumers in the arithmetic datapath.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; product width is 2*WIDTH.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transaction offered
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand M
b  input  WIDTH  multiplier X (Booth-recoded)
signed_mode  input  1  1 = a, b two's complement; 0 = unsigned; sampled with a, b
out_valid  output  1  product available
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  a*b, interpreted per the captured signed_mode
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at a rising clk edge) has priority over everything:
  - state=IDLE; in_ready=1, out_valid=0, busy=0, product=0, accumulator and digit counter cleared.
  - Any in-flight operation is abandoned; no result is produced for it.
- Operand extension on accept: a and b are each extended to WIDTH+2 bits, sign-extended if signed_mode=1, zero-extended if 0. The extended multiplier has an implicit bit x[-1]=0.
- N = WIDTH/2+1 Booth digits, always; the unsigned case needs no special path.
- Digit i uses bits {x[2i+1], x[2i], x[2i-1]}. Partial product per digit:
  - 000, 111 -> 0
  - 001, 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101, 110 -> -M
- Accumulator is 2*WIDTH+4 bits signed. Each digit does acc += sign-extended PP << 2i. product = acc[2*WIDTH-1:0], exact for both modes.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: capture extended a, b and signed_mode; acc=0; digit=0; go to CALC.
  - CALC: in_ready=0. Each cycle add digit `digit` and increment. On the edge adding digit N-1, load product and go to DONE.
  - DONE: out_valid=1; product held stable. On out_valid&out_ready, go to IDLE (out_valid drops the next cycle).
- Latency: accept on edge k -> out_valid high after edge k+N (5 cycles for WIDTH=8, 9 for WIDTH=16).
- Throughput: one result per N+2 cycles at best. No accept in the same cycle as output handshake; in_ready is only high in IDLE.
- Operand-port rules:
  - in_valid while busy is ignored; operands are not queued.
  - a, b and signed_mode may change after the accept edge without effect.
- Output hold: product and out_valid stay stable while out_ready=0, for any number of cycles.
- out_ready asserted outside DONE has no effect.
- product keeps the last result until the next DONE load or reset.

Test Plan:
- WIDTH=8, signed_mode=0, out_ready=1: a=10, b=10 -> product=100, out_valid exactly 5 cycles after accept. Then a=255, b=255 -> 65025; a=200, b=210 -> 42000.
- WIDTH=8, signed_mode=1 corners:
  - a=8'h80, b=8'h80 -> 16384 (16'h4000).
  - a=8'hFF, b=8'hFF -> 1.
  - a=8'h7F, b=8'h80 -> -16256 (16'hC080).
  - a=0, b=8'h80 -> 0.
- Backpressure: complete a=15, b=20 (signed or unsigned) with out_ready=0 for 7 cycles -> out_valid=1 and product=300 held constant. in_valid pulses with new operands during this time are ignored. After out_ready=1, one handshake, then in_ready=1 the next cycle.
- Reset mid-operation: assert rst for 1 cycle 2 cycles into CALC -> out_valid, busy, product all 0 and in_ready=1 the next cycle. A fresh a=30, b=40 then gives 1200 with normal latency.
- Random regression, WIDTH=8 and WIDTH=16, 2000 transactions each:
  - random signed_mode, in_valid and out_ready duty.
  - each product checked against a reference multiply of the captured operands.
  - WIDTH=16 latency must be 9 cycles.
